// File: rtl/float_pkg.sv
// Shared definitions for the float arg-max stream: comparator flag positions,
// FSM state encoding and the word-width helper.
package float_pkg;

    localparam int unsigned FLAG_GT = 2;
    localparam int unsigned FLAG_EQ = 1;
    localparam int unsigned FLAG_LT = 0;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_t;

    function automatic int unsigned word_w(input int unsigned exp_w, input int unsigned man_w);
        return 1 + exp_w + man_w;
    endfunction

endpackage

// File: rtl/float_cmp_comb.sv
// Combinational sign-magnitude float compare; flag is one-hot {a>b, a==b, a<b}.
module float_cmp_comb
    import float_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic [word_w(EXP_W, MAN_W)-1:0] a,
    input  logic [word_w(EXP_W, MAN_W)-1:0] b,
    output logic [2:0]                      flag
);

    localparam int unsigned M = EXP_W + MAN_W;

    logic         sa;
    logic         sb;
    logic [M-1:0] ma;
    logic [M-1:0] mb;

    assign sa = a[M];
    assign sb = b[M];
    assign ma = a[M-1:0];
    assign mb = b[M-1:0];

    always_comb begin
        flag = '0;
        if (ma == '0 && mb == '0) begin
            flag[FLAG_EQ] = 1'b1;
        end else if (sa != sb) begin
            if (sa) flag[FLAG_LT] = 1'b1;
            else    flag[FLAG_GT] = 1'b1;
        end else if (ma == mb) begin
            flag[FLAG_EQ] = 1'b1;
        end else if ((ma > mb) ^ sa) begin
            // Larger magnitude wins when positive, loses when negative.
            flag[FLAG_GT] = 1'b1;
        end else begin
            flag[FLAG_LT] = 1'b1;
        end
    end

endmodule

// File: rtl/float_argmax_stream.sv
// Streaming arg-max over one packet of floats with valid/ready handshakes.
// Optional FLOAT_NAN_SKIP_EN: NaN elements never win and are reported on out_nan.
module float_argmax_stream
    import float_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned IDX_W = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [word_w(EXP_W, MAN_W)-1:0] in_data,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [word_w(EXP_W, MAN_W)-1:0] out_max,
    output logic [IDX_W-1:0]                out_idx,
`ifdef FLOAT_NAN_SKIP_EN
    output logic                            out_nan,
`endif
    output logic                            out_ovf
);

    localparam int unsigned W = word_w(EXP_W, MAN_W);
    localparam logic [IDX_W-1:0] CntMax = '1;

    state_t           state;
    logic [W-1:0]     max_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] cnt_q;
    logic             ovf_q;
    logic             valid_q;
    logic [2:0]       flag;
    logic             accept;
    logic             take;
    logic             unused_flags;

    float_cmp_comb #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_cmp (
        .a   (in_data),
        .b   (max_q),
        .flag(flag)
    );

    assign unused_flags = ^{flag[FLAG_EQ], flag[FLAG_LT]};
    assign in_ready     = (state != StDone);
    assign accept       = in_valid && in_ready;

`ifdef FLOAT_NAN_SKIP_EN
    logic in_nan;
    logic max_nan_q;
    logic nan_q;

    assign in_nan = (&in_data[W-2 -: EXP_W]) && (|in_data[MAN_W-1:0]);
    // A provisional NaN max yields to the first non-NaN element regardless of value.
    assign take   = !in_nan && (max_nan_q || flag[FLAG_GT]);
    assign out_nan = nan_q;
`else
    assign take = flag[FLAG_GT];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            max_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef FLOAT_NAN_SKIP_EN
            max_nan_q <= 1'b0;
            nan_q     <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        max_q <= in_data;
                        idx_q <= '0;
                        cnt_q <= IDX_W'(1);
`ifdef FLOAT_NAN_SKIP_EN
                        max_nan_q <= in_nan;
                        nan_q     <= in_nan;
`endif
                        if (in_last) begin
                            state   <= StDone;
                            valid_q <= 1'b1;
                        end else begin
                            state <= StAccum;
                        end
                    end
                end
                StAccum: begin
                    if (accept) begin
                        if (take) begin
                            max_q <= in_data;
                            idx_q <= cnt_q;
`ifdef FLOAT_NAN_SKIP_EN
                            max_nan_q <= 1'b0;
`endif
                        end
`ifdef FLOAT_NAN_SKIP_EN
                        nan_q <= nan_q | in_nan;
`endif
                        // Past the last representable index the count sticks and idx freezes.
                        if (cnt_q == CntMax) ovf_q <= 1'b1;
                        else                 cnt_q <= cnt_q + 1'b1;
                        if (in_last) begin
                            state   <= StDone;
                            valid_q <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state   <= StIdle;
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
`ifdef FLOAT_NAN_SKIP_EN
                        nan_q <= 1'b0;
`endif
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign out_valid = valid_q;
    assign out_max   = max_q;
    assign out_idx   = idx_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_float_argmax_stream.sv
// Directed bench for float_argmax_stream: default instance plus an IDX_W=2 instance for overflow.
module tb_float_argmax_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;

    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
    logic [31:0] in_data, out_max;
    logic [7:0]  out_idx;
`ifdef FLOAT_NAN_SKIP_EN
    logic        out_nan;
`endif

    logic        in_valid2, in_ready2, in_last2, out_valid2, out_ready2, out_ovf2;
    logic [31:0] in_data2, out_max2;
    logic [1:0]  out_idx2;
`ifdef FLOAT_NAN_SKIP_EN
    logic        out_nan2;
`endif

    always #5 clk = ~clk;

    float_argmax_stream dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_max  (out_max),
        .out_idx  (out_idx),
`ifdef FLOAT_NAN_SKIP_EN
        .out_nan  (out_nan),
`endif
        .out_ovf  (out_ovf)
    );

    float_argmax_stream #(
        .EXP_W(8),
        .MAN_W(23),
        .IDX_W(2)
    ) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid2),
        .in_ready (in_ready2),
        .in_data  (in_data2),
        .in_last  (in_last2),
        .out_valid(out_valid2),
        .out_ready(out_ready2),
        .out_max  (out_max2),
        .out_idx  (out_idx2),
`ifdef FLOAT_NAN_SKIP_EN
        .out_nan  (out_nan2),
`endif
        .out_ovf  (out_ovf2)
    );

    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send2(input logic [31:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        in_valid2 = 1'b1;
        in_data2  = d;
        in_last2  = l;
        while (!in_ready2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready2) begin
            errors++;
            $display("FAIL send2_timeout in_ready=%0b required 1", in_ready2);
        end
        @(posedge clk);
        #1 in_valid2 = 1'b0;
    endtask

    // Waits (bounded) for a result, captures it, then completes the handoff.
    task automatic wait_result(output logic [31:0] m, output logic [7:0] i, output logic o,
                               output logic got);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        got = out_valid;
        m   = out_max;
        i   = out_idx;
        o   = out_ovf;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic wait_result2(output logic [31:0] m, output logic [1:0] i, output logic o,
                                output logic got);
        int n = 0;
        @(negedge clk);
        while (!out_valid2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        got = out_valid2;
        m   = out_max2;
        i   = out_idx2;
        o   = out_ovf2;
        out_ready2 = 1'b1;
        @(posedge clk);
        #1 out_ready2 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_max !== 32'h0 || out_idx !== 8'h0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b m=%h i=%0d o=%0b required 0/0/0/0",
                     out_valid, out_max, out_idx, out_ovf);
        end
        checks++;
        if (out_valid2 !== 1'b0 || out_ovf2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut2 got v=%0b o=%0b required 0/0", out_valid2, out_ovf2);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || in_ready2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %0b/%0b required 1/1", in_ready, in_ready2);
        end
    endtask

    task automatic test_basic;
        logic [31:0] m;
        logic [7:0]  i;
        logic        o, got;
        send(32'h3f800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h3f800000, 1'b1);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency out_valid=%0b required 1", out_valid);
        end
        wait_result(m, i, o, got);
        checks++;
        if (got !== 1'b1 || m !== 32'h40000000 || i !== 8'd1 || o !== 1'b0) begin
            errors++;
            $display("FAIL basic_result got v=%0b m=%h i=%0d o=%0b required 1/40000000/1/0",
                     got, m, i, o);
        end
    endtask

    task automatic test_negatives;
        logic [31:0] m;
        logic [7:0]  i;
        logic        o, got;
        send(32'hc0000000, 1'b0);
        send(32'hbf800000, 1'b0);
        send(32'hc0400000, 1'b1);
        wait_result(m, i, o, got);
        checks++;
        if (got !== 1'b1 || m !== 32'hbf800000 || i !== 8'd1) begin
            errors++;
            $display("FAIL negatives got v=%0b m=%h i=%0d required 1/bf800000/1", got, m, i);
        end
        send(32'h80000000, 1'b0);
        send(32'h00000000, 1'b1);
        wait_result(m, i, o, got);
        checks++;
        if (got !== 1'b1 || m !== 32'h80000000 || i !== 8'd0) begin
            errors++;
            $display("FAIL zeros_tie got v=%0b m=%h i=%0d required 1/80000000/0", got, m, i);
        end
    endtask

    task automatic test_hold;
        logic [31:0] m;
        logic [7:0]  i;
        logic        o, got;
        send(32'h40000000, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_max !== 32'h40000000 ||
                out_idx !== 8'd0) begin
                errors++;
                $display("FAIL hold_cycle%0d got rdy=%0b v=%0b m=%h i=%0d required 0/1/40000000/0",
                         k, in_ready, out_valid, out_max, out_idx);
            end
        end
        // Offer the next packet in the same cycle as the handoff; it must wait a cycle.
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 32'h3f800000;
        in_last   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_handoff got v=%0b rdy=%0b required 0/1", out_valid, in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result(m, i, o, got);
        checks++;
        if (got !== 1'b1 || m !== 32'h3f800000 || i !== 8'd0) begin
            errors++;
            $display("FAIL hold_next got v=%0b m=%h i=%0d required 1/3f800000/0", got, m, i);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] beats [12] = '{32'h3f000000, 32'hbf000000, 32'h41200000,
                                    32'hff800000, 32'hc1200000, 32'hc1200000,
                                    32'h00000001, 32'h00000000, 32'h80000001,
                                    32'h7f800000, 32'h7f7fffff, 32'h7f800000};
        logic [31:0] exp_max [4] = '{32'h41200000, 32'hc1200000, 32'h00000001, 32'h7f800000};
        logic [7:0]  exp_idx [4] = '{8'd2, 8'd1, 8'd0, 8'd0};
        out_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 3; b++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(beats[p*3+b], b == 2);
            end
            checks++;
            if (out_valid !== 1'b1 || out_max !== exp_max[p] || out_idx !== exp_idx[p] ||
                out_ovf !== 1'b0) begin
                errors++;
                $display("FAIL b2b_pkt%0d got v=%0b m=%h i=%0d o=%0b required 1/%h/%0d/0",
                         p, out_valid, out_max, out_idx, out_ovf, exp_max[p], exp_idx[p]);
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_ovf;
        logic [31:0] seq [6] = '{32'h3f800000, 32'h3f800000, 32'h40000000,
                                 32'h40400000, 32'h40800000, 32'h40a00000};
        logic [31:0] m;
        logic [1:0]  i;
        logic        o, got;
        for (int k = 0; k < 6; k++) send2(seq[k], k == 5);
        wait_result2(m, i, o, got);
        checks++;
        if (got !== 1'b1 || m !== 32'h40a00000 || i !== 2'd3 || o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_result got v=%0b m=%h i=%0d o=%0b required 1/40a00000/3/1",
                     got, m, i, o);
        end
        send2(32'h3f800000, 1'b0);
        send2(32'h40000000, 1'b1);
        wait_result2(m, i, o, got);
        checks++;
        if (got !== 1'b1 || m !== 32'h40000000 || i !== 2'd1 || o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_cleared got v=%0b m=%h i=%0d o=%0b required 1/40000000/1/0",
                     got, m, i, o);
        end
        send2(32'h3f800000, 1'b0);
        send2(32'h40400000, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_valid got %0b required 0", out_valid2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready2 !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready got %0b required 1", in_ready2);
        end
        send2(32'h40000000, 1'b1);
        wait_result2(m, i, o, got);
        checks++;
        if (got !== 1'b1 || m !== 32'h40000000 || i !== 2'd0 || o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_next got v=%0b m=%h i=%0d o=%0b required 1/40000000/0/0",
                     got, m, i, o);
        end
    endtask

    task automatic test_nan;
        logic [31:0] m;
        logic [7:0]  i;
        logic        o, got;
        send(32'h7fc00000, 1'b0);
        send(32'h3f800000, 1'b1);
`ifdef FLOAT_NAN_SKIP_EN
        checks++;
        if (out_nan !== 1'b1) begin
            errors++;
            $display("FAIL nan_flag got %0b required 1", out_nan);
        end
        wait_result(m, i, o, got);
        checks++;
        if (got !== 1'b1 || m !== 32'h3f800000 || i !== 8'd1) begin
            errors++;
            $display("FAIL nan_skip got v=%0b m=%h i=%0d required 1/3f800000/1", got, m, i);
        end
`else
        wait_result(m, i, o, got);
        checks++;
        if (got !== 1'b1 || m !== 32'h7fc00000 || i !== 8'd0) begin
            errors++;
            $display("FAIL nan_raw got v=%0b m=%h i=%0d required 1/7fc00000/0", got, m, i);
        end
`endif
    endtask

    initial begin
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        in_valid2  = 1'b0;
        in_data2   = '0;
        in_last2   = 1'b0;
        out_ready2 = 1'b0;
        test_reset();
        test_basic();
        test_negatives();
        test_hold();
        test_back_to_back();
        test_ovf();
        test_nan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
